// File: rtl/seven_seg_scan.sv
// Time-multiplexed digit scanner with per-slot blanking and a double-buffered display word.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seven_seg_scan #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DIGIT_CYCLES = 50000,
   parameter int unsigned BLANK_CYCLES = 16,
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic                    data_valid,
   input  logic                    enable,
   output logic [3:0]              nibble_out,
   output logic [NUM_DIGITS-1:0]   digit_sel_n,
   output logic [IdxW-1:0]         digit_idx,
   output logic                    frame_done,
   output logic                    pending
);

   logic [CntW-1:0]         r_count, w_cnt_d;
   logic [IdxW-1:0]         r_idx, w_idx_d;
   logic                    r_run, w_run_d;
   logic [4*NUM_DIGITS-1:0] r_display, w_disp_d;
   logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow_d;
   logic                    r_pending, w_pend_d;
   logic [3:0]              r_nibble, w_nibble_d;
   logic [NUM_DIGITS-1:0]   r_sel_n, w_sel_d;
   logic                    r_frame_done, w_frame_d;
   logic                    w_last_cnt, w_last_idx, w_boundary, w_in_blank;
   logic [NUM_DIGITS-1:0]   w_lz;

   assign w_last_cnt = (r_count == CntW'(DIGIT_CYCLES - 1));
   assign w_last_idx = (r_idx == IdxW'(NUM_DIGITS - 1));

   // r_run is low after reset or while dark; the first running edge lands on count 0 of slot 0.
   always_comb begin
      w_cnt_d    = r_count;
      w_idx_d    = r_idx;
      w_run_d    = r_run;
      w_disp_d   = r_display;
      w_shadow_d = r_shadow;
      w_pend_d   = r_pending;
      w_frame_d  = 1'b0;
      w_boundary = 1'b0;
      if (!enable) begin
         w_cnt_d = '0;
         w_idx_d = '0;
         w_run_d = 1'b0;
         if (r_pending) begin
            w_disp_d = r_shadow;
            w_pend_d = 1'b0;
         end
         if (data_valid) begin
            w_disp_d   = data_in;
            w_shadow_d = data_in;
            w_pend_d   = 1'b0;
         end
      end else begin
         w_run_d = 1'b1;
         if (!r_run) begin
            w_cnt_d = '0;
            w_idx_d = '0;
         end else if (w_last_cnt) begin
            w_cnt_d    = '0;
            w_idx_d    = w_last_idx ? '0 : r_idx + 1'b1;
            w_boundary = w_last_idx;
         end else begin
            w_cnt_d = r_count + 1'b1;
         end
         if (w_boundary) begin
            w_frame_d = 1'b1;
            if (r_pending) begin
               w_disp_d = r_shadow;
               w_pend_d = 1'b0;
            end
         end
         if (data_valid) begin
            w_shadow_d = data_in;
            if (w_boundary) begin
               w_disp_d = data_in;
            end else begin
               w_pend_d = 1'b1;
            end
         end
      end
   end

   if (BLANK_CYCLES > 0) begin : g_blank
      assign w_in_blank = (w_cnt_d < CntW'(BLANK_CYCLES));
   end else begin : g_no_blank
      assign w_in_blank = 1'b0;
   end

   always_comb begin
      w_lz = '0;
`ifdef SEG_SCAN_LZB_EN
      begin
         logic w_zero_above;
         w_zero_above = 1'b1;
         for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above && (w_disp_d[4*k +: 4] == 4'h0);
            w_lz[k]      = w_zero_above;
         end
      end
`endif
   end

   always_comb begin
      w_nibble_d = '0;
      w_sel_d    = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (w_idx_d == IdxW'(k)) begin
            w_nibble_d = w_disp_d[4*k +: 4];
            w_sel_d[k] = ~(w_run_d && !w_in_blank && !w_lz[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count      <= '0;
         r_idx        <= '0;
         r_run        <= 1'b0;
         r_display    <= '0;
         r_shadow     <= '0;
         r_pending    <= 1'b0;
         r_nibble     <= '0;
         r_sel_n      <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_count      <= w_cnt_d;
         r_idx        <= w_idx_d;
         r_run        <= w_run_d;
         r_display    <= w_disp_d;
         r_shadow     <= w_shadow_d;
         r_pending    <= w_pend_d;
         r_nibble     <= w_nibble_d;
         r_sel_n      <= w_sel_d;
         r_frame_done <= w_frame_d;
      end
   end

   assign nibble_out  = r_nibble;
   assign digit_sel_n = r_sel_n;
   assign digit_idx   = r_idx;
   assign frame_done  = r_frame_done;
   assign pending     = r_pending;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed scenarios plus random traffic against a
// time-based reference model. Define SEG_SCAN_LZB_EN to check leading-zero blanking.
module tb_seven_seg_scan;

   localparam int N  = 4;
   localparam int DC = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data_in = '0;
   logic        data_valid = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  nibble_out;
   logic [3:0]  digit_sel_n;
   logic [1:0]  digit_idx;
   logic        frame_done;
   logic        pending;

   seven_seg_scan #(
      .NUM_DIGITS  (N),
      .DIGIT_CYCLES(DC),
      .BLANK_CYCLES(BC)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .enable     (enable),
      .nibble_out (nibble_out),
      .digit_sel_n(digit_sel_n),
      .digit_idx  (digit_idx),
      .frame_done (frame_done),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: m_t = cycles since scanning (re)started, -1 while reset or dark.
   int          m_t = -1;
   logic [15:0] m_disp = '0;
   logic [15:0] m_shadow = '0;
   logic        m_pend = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic dv, input logic [15:0] d);
      int          cnt, idx;
      logic        boundary, lit;
      logic [3:0]  nib, sel;
      logic [15:0] upper;
      rst = r; enable = e; data_valid = dv; data_in = d;
      @(posedge clk);
      boundary = 1'b0;
      if (r) begin
         m_t = -1; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
      end else if (!e) begin
         m_t = -1;
         if (m_pend) m_disp = m_shadow;
         m_pend = 1'b0;
         if (dv) begin m_disp = d; m_shadow = d; end
      end else begin
         m_t = (m_t < 0) ? 0 : m_t + 1;
         boundary = (m_t > 0) && (m_t % (DC * N) == 0);
         if (boundary && m_pend) begin m_disp = m_shadow; m_pend = 1'b0; end
         if (dv) begin
            m_shadow = d;
            if (boundary) m_disp = d; else m_pend = 1'b1;
         end
      end
      if (m_t < 0) begin
         cnt = 0; idx = 0; lit = 1'b0;
      end else begin
         cnt = m_t % DC; idx = (m_t / DC) % N; lit = (cnt >= BC);
      end
      nib = m_disp[4*idx +: 4];
      upper = m_disp >> (4 * idx);
`ifdef SEG_SCAN_LZB_EN
      if (idx > 0 && upper == 16'h0) lit = 1'b0;
`endif
      sel = lit ? ~(4'b0001 << idx) : 4'b1111;
      #1;
      check("nibble_out", 32'(nibble_out), 32'(nib));
      check("digit_sel_n", 32'(digit_sel_n), 32'(sel));
      check("digit_idx", 32'(digit_idx), 32'(idx));
      check("frame_done", 32'(frame_done), 32'(boundary));
      check("pending", 32'(pending), 32'(m_pend));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
   endtask

   task automatic run_to_slot(input int slot);
      for (int i = 0; i < DC * N && ((m_t < 0) || ((m_t / DC) % N != slot)); i++) idle(1);
   endtask

   initial begin
      repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0);
      check("reset_sel", 32'(digit_sel_n), 32'hF);
      idle(12);

      // Mid-frame load waits for the boundary.
      step(1'b0, 1'b1, 1'b1, 16'h1234);
      check("load_pending", 32'(pending), 32'h1);
      idle(80);

      // Load exactly on the boundary edge: bypass straight to display.
      for (int i = 0; i < DC * N && ((m_t + 1) % (DC * N) != 0); i++) idle(1);
      step(1'b0, 1'b1, 1'b1, 16'hABCD);
      check("bypass_nibble", 32'(nibble_out), 32'hD);
      check("bypass_pending", 32'(pending), 32'h0);
      idle(40);

      // Drop enable in slot 2 with a pending word, then re-enable.
      run_to_slot(2);
      step(1'b0, 1'b1, 1'b1, 16'h00FF);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("dark_sel", 32'(digit_sel_n), 32'hF);
      idle(0);
      repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("restart_nibble", 32'(nibble_out), 32'hF);
      idle(40);

      // Reset in slot 3 while a word is pending.
      run_to_slot(3);
      step(1'b0, 1'b1, 1'b1, 16'h5A5A);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      check("rst_pending", 32'(pending), 32'h0);
      idle(40);

      // Leading-zero patterns (blanked only in the LZB build).
      step(1'b0, 1'b1, 1'b1, 16'h0050);
      idle(70);
      step(1'b0, 1'b1, 1'b1, 16'h0000);
      idle(70);

      for (int i = 0; i < 3000; i++) begin
         logic        r, e, dv;
         logic [15:0] d;
         r  = ($urandom_range(0, 299) == 0);
         e  = ($urandom_range(0, 99) != 0);
         dv = ($urandom_range(0, 9) == 0);
         d  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         step(r, e, dv, d);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
